// File: rtl/sram_acc.sv
// sram_acc: single-port accumulate SRAM for systolic-array partial sums.
// Read latency 1; accumulate commits one cycle after acceptance with full forwarding.
// Commands are ignored while the clear sweep runs (busy=1). Optional macro: SRAM_ACC_SAT_EN.
module sram_acc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wen,
  input  logic              acc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  input  logic              clr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // Accumulate stage: holds the already-summed result waiting to be written back.
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_val;

  logic              cmd_ok, is_rd, is_wr, is_acc;
  logic [DATA_W-1:0] cur_val, acc_val;

  // clr wins over a simultaneous command; nothing is accepted during the sweep.
  assign cmd_ok = en && !busy && !clr;
  assign is_rd  = cmd_ok && wen;
  assign is_wr  = cmd_ok && !wen && !acc;
  assign is_acc = cmd_ok && !wen && acc;

  // Logical value of mem[addr]: a pending accumulate to the same word is forwarded.
  assign cur_val = (pend && (pend_addr == addr)) ? pend_val : mem[addr];

`ifdef SRAM_ACC_SAT_EN
  logic [DATA_W:0] sum_full;
  assign sum_full = {1'b0, cur_val} + {1'b0, d};
  assign acc_val  = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
  assign acc_val  = cur_val + d;
`endif

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear FSM next state: sweep starts on clr when idle, ends after the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr)      state_nxt = CLEAR;
      CLEAR:   if (&clr_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
  end

  // Sweep counter; wraps back to 0 naturally after the last word.
  always_ff @(posedge clk) begin
    if (!rst_n)              clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Pending flag; reset drops an in-flight accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= is_acc;
  end

  // Stage payload, captured on every accepted accumulate.
  always_ff @(posedge clk) begin
    if (is_acc) begin
      pend_addr <= addr;
      pend_val  <= acc_val;
    end
  end

  // Registered read port; q holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= is_rd;
      if (is_rd) q <= cur_val;
    end
  end

  // Array writes: sweep zeroing, accumulate commit, plain write (a same-address write beats the commit).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) mem[clr_cnt] <= '0;
      if (pend && !(is_wr && (addr == pend_addr))) mem[pend_addr] <= pend_val;
      if (is_wr) mem[addr] <= d;
    end
  end

endmodule

// File: tb/tb_sram_acc.sv
// Self-checking bench for sram_acc (DATA_W=8, ADDR_W=4): directed scenarios plus random traffic
// checked every cycle against a word-level model of the array.
module tb_sram_acc;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, wen = 1'b1, acc = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] q;
  logic          q_valid, busy;

  sram_acc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wen(wen), .acc(acc),
    .addr(addr), .d(d), .clr(clr), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Word-level model: commands take effect immediately in logical order.
  logic [DW-1:0] mdl [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] q_e = '0;
  bit            q_known_e = 1'b1;
  bit            qv_e = 1'b0;
  bit            busy_e = 1'b0;
  int            clr_idx = 0;
  bit            model_on = 1'b0;

  function automatic logic [DW-1:0] acc_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef SRAM_ACC_SAT_EN
    if (s > 255) return 8'hFF;
`endif
    return DW'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q_e = '0; q_known_e = 1'b1; qv_e = 1'b0;
      if (busy_e) known[clr_idx] = 1'b0;
      busy_e = 1'b0;
    end else if (busy_e) begin
      mdl[clr_idx] = '0; known[clr_idx] = 1'b1;
      clr_idx++;
      if (clr_idx == DEPTH) busy_e = 1'b0;
      qv_e = 1'b0;
    end else if (clr) begin
      busy_e = 1'b1; clr_idx = 0; qv_e = 1'b0;
    end else if (en) begin
      if (wen) begin
        q_e = mdl[addr]; q_known_e = known[addr]; qv_e = 1'b1;
      end else begin
        if (acc) mdl[addr] = acc_fn(mdl[addr], d);
        else begin mdl[addr] = d; known[addr] = 1'b1; end
        qv_e = 1'b0;
      end
    end else begin
      qv_e = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("busy", 32'(busy), 32'(busy_e));
      check("q_valid", 32'(q_valid), 32'(qv_e));
      if (q_known_e) check("q", 32'(q), 32'(q_e));
    end
  end

  task automatic issue(input bit e, input bit w, input bit a, input int ad, input int dd, input bit c);
    en = e; wen = w; acc = a; addr = AW'(ad); d = DW'(dd); clr = c;
    @(negedge clk);
  endtask
  task automatic idle();                      issue(0, 1, 0, 0, 0, 0);   endtask
  task automatic wr(input int ad, input int dd);    issue(1, 0, 0, ad, dd, 0); endtask
  task automatic accum(input int ad, input int dd); issue(1, 0, 1, ad, dd, 0); endtask
  task automatic rd(input int ad);                  issue(1, 1, 0, ad, 0, 0);  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_q", 32'(q), 0);
    check("reset_q_valid", 32'(q_valid), 0);
    rst_n = 1'b1;
    model_on = 1'b1;

    // Write then read
    wr(3, 'h5A); rd(3);
    check("wr_rd_q", 32'(q), 'h5A);
    check("wr_rd_valid", 32'(q_valid), 1);
    idle();
    check("valid_one_cycle", 32'(q_valid), 0);

    // Accumulate chain with forwarding
    wr(7, 'h10); accum(7, 1); accum(7, 2); accum(7, 3); rd(7);
    check("acc_chain", 32'(q), 'h16);

    // Overflow
    wr(2, 'hF0); accum(2, 'h20); rd(2);
`ifdef SRAM_ACC_SAT_EN
    check("overflow", 32'(q), 'hFF);
`else
    check("overflow", 32'(q), 'h10);
`endif

    // Collision: write after accumulate to same word wins
    wr(4, 1); accum(4, 5); wr(4, 'h77); rd(4);
    check("collision", 32'(q), 'h77);

    // Clear with a simultaneous write that must be dropped; commands during busy ignored
    for (int i = 0; i < DEPTH; i++) wr(i, 'hAA);
    issue(1, 0, 0, 0, 'h33, 1);
    cnt = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      cnt++;
      issue(1, k[0], 0, k % DEPTH, 'h55, k[1]);
    end
    check("clear_busy_cycles", 32'(cnt), 16);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      check("clear_read", 32'(q), 0);
    end

    // Reset on the 5th busy cycle of a clear
    for (int i = 0; i < DEPTH; i++) wr(i, 'hAA);
    issue(0, 1, 0, 0, 0, 1);
    repeat (4) idle();
    check("busy_before_reset", 32'(busy), 1);
    rst_n = 1'b0;
    idle();
    check("rst_busy", 32'(busy), 0);
    check("rst_q", 32'(q), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 4) begin
        rd(i);
        check("abort_read", 32'(q), (i < 4) ? 0 : 'hAA);
      end
    end

    // Random traffic against the model
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 255));
    for (int k = 0; k < 500; k++) begin
      issue(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
            $urandom_range(0, DEPTH-1), $urandom_range(0, 255), ($urandom % 60) == 0);
    end
    idle();
    for (int k = 0; k < 40 && busy === 1'b1; k++) idle();
    for (int i = 0; i < DEPTH; i++) rd(i);
    idle();

    summary();
    $finish;
  end
endmodule

// File: doc/sram_acc.md
# sram_acc

Parametrised single-port accumulate SRAM for systolic-array output storage. Each access can read, overwrite, or accumulate, where accumulate means `mem[addr] += d` in a two-stage read-modify-write with full forwarding. A one-shot clear sequencer zeroes the whole array. The block sits between the systolic array's partial-sum outputs and the testbench/host readback path, and supersedes the fixed 8-bit × 2048 output buffer.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 11: address width in bits; depth is `DEPTH = 1 << ADDR_W`.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `en`, input, 1: command strobe; the command is accepted at a rising edge when `en=1` and `busy=0`.
- `wen`, input, 1: active-low write; 1 = read, 0 = write or accumulate.
- `acc`, input, 1: with `wen=0`, 1 = accumulate, 0 = plain write; ignored on reads.
- `addr`, input, `ADDR_W`: word address.
- `d`, input, `DATA_W`: write data or addend.
- `clr`, input, 1: start a full-array clear; sampled only when `busy=0`.
- `q`, output, `DATA_W`: registered read data.
- `q_valid`, output, 1: high for exactly the one cycle following each accepted read.
- `busy`, output, 1: clear sweep in progress; commands are ignored while high.

## Operation
- **Storage:** `DEPTH × DATA_W` array. Contents are not reset and are undefined until written or cleared.
- **Read** (`wen=1`), accepted at edge N:
  - At edge N, `q` loads the current logical value of `mem[addr]` and `q_valid` goes to 1.
  - The logical value includes every write or accumulate accepted before edge N, including a pending accumulate (forwarding is required).
  - When no read is accepted, `q` holds its value and `q_valid` goes to 0.
- **Write** (`wen=0`, `acc=0`), accepted at edge N: `mem[addr] <= d` at edge N.
- **Accumulate** (`wen=0`, `acc=1`), accepted at edge N:
  - Stage register captures `addr` and `d`, and the pending flag is set.
  - At edge N+1 the stage commits `mem[addr] <= old + d`, where `old` is the logical value at edge N.
  - Back-to-back accumulates to the same address chain correctly; two accumulates of +1 yield old+2.
- **Collision:** a plain write accepted at edge N+1 to the same address as the accumulate committing at edge N+1 wins. The final value is the write data and the commit is discarded.
- **Arithmetic:** unsigned `DATA_W`-bit; wraps modulo `2^DATA_W` (see Configuration).
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE → CLEAR when `clr=1` at an edge with `busy=0`. `clr` takes priority over a simultaneous `en`, and that command is dropped.
  - A pending accumulate still commits at that edge.
  - In CLEAR, the counter runs 0 to `DEPTH-1`, writing zero to one word per cycle.
  - CLEAR → IDLE after word `DEPTH-1` is written.
  - `clr` is ignored while in CLEAR.
- **Reset** (`rst_n=0` at an edge):
  - `q=0`, `q_valid=0`, `busy=0`, FSM goes to IDLE, clear counter goes to 0.
  - A pending accumulate is dropped.
  - Reset during CLEAR aborts the sweep; already-zeroed words stay zero and the rest keep their values.

## Timing
- Read latency is 1: address at edge N, data valid in the cycle after N.
- Throughput is one command per cycle with no stalls outside CLEAR.
- Accumulate commits one cycle after acceptance; the result is visible to a read accepted at edge N+1 via forwarding.
- `busy` rises in the cycle after `clr` is accepted and stays high for exactly `DEPTH` cycles.
- The first command is accepted at the edge where `busy` is seen low.
- `q` and `q_valid` are not updated during CLEAR.

## Configuration
- **`SRAM_ACC_SAT_EN`**
  - Defined: accumulate saturates, so if `old + d > 2^DATA_W - 1` the stored result is all-ones.
  - Undefined: the stored result is `(old + d) mod 2^DATA_W`.
  - Plain writes are unaffected either way.

## Test plan
Benches use `DATA_W=8` and `ADDR_W=4`.
- **Write then read:** write 0x5A to addr 3, then read addr 3 on the next cycle → `q=0x5A` with `q_valid=1` for one cycle.
- **Accumulate chain:** write 0x10 to addr 7, then accumulate +0x01, +0x02, +0x03 on consecutive cycles, then read addr 7 on the next cycle → `q=0x16`.
- **Overflow:** write 0xF0 to addr 2, accumulate +0x20, read addr 2 → `q=0x10` without the macro and `q=0xFF` with `SRAM_ACC_SAT_EN`.
- **Collision:** accumulate +0x05 to addr 4 (old 0x01), then a write of 0x77 to addr 4 on the next cycle, then a read → `q=0x77`.
- **Clear:** fill all 16 words with 0xAA, pulse `clr` alongside a write to addr 0 → `busy=1` for exactly 16 cycles, the write is dropped, and reads of all 16 addresses return 0x00.
- **Reset mid-operation:** start a clear and assert `rst_n=0` on the 5th `busy` cycle → `busy`, `q`, and `q_valid` are 0 at the next edge. Addrs 0–3 read 0x00 and addrs ≥5 read 0xAA.
